// File: rtl/aes_pkg.sv
// Shared AES constants, byte-level GF(2^8) helpers and the iterative-core state encoding.
package aes_pkg;

   localparam int BLOCK_W = 128;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic int nr_of(input int nk);
      return nk + 6;
   endfunction

   function automatic logic [7:0] xTime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant; enough for the InvMixColumns coefficients 9, b, d, e.
   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [3:0] m);
      logic [7:0] x2, x4, x8;
      x2 = xTime(a);
      x4 = xTime(x2);
      x8 = xTime(x4);
      return ({8{m[0]}} & a) ^ ({8{m[1]}} & x2) ^ ({8{m[2]}} & x4) ^ ({8{m[3]}} & x8);
   endfunction

endpackage

// File: rtl/aes_inv_round_core.sv
// One combinational AES decryption round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless isFinal. Byte n of the block sits at column n/4, row n%4.
module aes_inv_round_core
   import aes_pkg::*;
(
   input  logic [0:BLOCK_W-1] stateIn,
   input  logic [0:BLOCK_W-1] roundKey,
   input  logic               isFinal,
   output logic [0:BLOCK_W-1] stateOut
);

   logic [7:0] keyed [16];

   // Row r rotates right by r columns, so output byte (c,r) comes from column (c-r) mod 4.
   function automatic int srcIdx(input int b);
      return 4 * (((b / 4) - (b % 4)) & 3) + (b % 4);
   endfunction

   always_comb begin
      for (int b = 0; b < 16; b++) begin
         keyed[b] = INV_SBOX[stateIn[8*srcIdx(b) +: 8]] ^ roundKey[8*b +: 8];
      end
   end

   always_comb begin
      // NOTE: default the whole output before the loop so no path can infer a latch.
      stateOut = '0;
      for (int c = 0; c < 4; c++) begin
         stateOut[32*c +: 8]      = isFinal ? keyed[4*c] :
            gfMul(keyed[4*c], 4'he) ^ gfMul(keyed[4*c+1], 4'hb) ^ gfMul(keyed[4*c+2], 4'hd) ^ gfMul(keyed[4*c+3], 4'h9);
         stateOut[32*c + 8 +: 8]  = isFinal ? keyed[4*c+1] :
            gfMul(keyed[4*c], 4'h9) ^ gfMul(keyed[4*c+1], 4'he) ^ gfMul(keyed[4*c+2], 4'hb) ^ gfMul(keyed[4*c+3], 4'hd);
         stateOut[32*c + 16 +: 8] = isFinal ? keyed[4*c+2] :
            gfMul(keyed[4*c], 4'hd) ^ gfMul(keyed[4*c+1], 4'h9) ^ gfMul(keyed[4*c+2], 4'he) ^ gfMul(keyed[4*c+3], 4'hb);
         stateOut[32*c + 24 +: 8] = isFinal ? keyed[4*c+3] :
            gfMul(keyed[4*c], 4'hb) ^ gfMul(keyed[4*c+1], 4'hd) ^ gfMul(keyed[4*c+2], 4'h9) ^ gfMul(keyed[4*c+3], 4'he);
      end
   end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock, with valid/ready on both sides and a
// tag carried alongside each block. Round keys arrive pre-expanded and are latched on accept.
module aes_inv_cipher_iter
   import aes_pkg::*;
#(
   parameter int  Nk    = 4,
   parameter int  TAG_W = 8,
   localparam int Nr    = nr_of(Nk)
) (
   input  logic                        clks,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [0:BLOCK_W-1]          in_data,
   input  logic [0:BLOCK_W*(Nr+1)-1]   in_keys,
   input  logic [TAG_W-1:0]            in_tag,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [0:BLOCK_W-1]          out_data,
   output logic [TAG_W-1:0]            out_tag,
   output logic                        busy,
   output logic [3:0]                  round_idx
);

   if (Nk != 4 && Nk != 6 && Nk != 8) begin : gBadNk
      $error("aes_inv_cipher_iter: Nk must be 4, 6 or 8");
   end

   state_t                      state, stateNext;
   logic [0:BLOCK_W-1]          stateReg, roundOut, roundKey;
   logic [0:BLOCK_W*(Nr+1)-1]   keysReg;
   logic [TAG_W-1:0]            tagReg;
   logic [3:0]                  cnt;
   logic                        accept, lastRound;

   assign lastRound = (cnt == 4'd0);
   assign accept    = in_valid & in_ready;
   assign busy      = (state == ROUND);
   assign out_valid = (state == DONE);
   assign round_idx = busy ? cnt : 4'd0;
   assign roundKey  = keysReg[BLOCK_W*cnt +: BLOCK_W];

   always_comb begin
      stateNext = state;
      in_ready  = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) stateNext = ROUND;
         end
         ROUND: if (lastRound) stateNext = DONE;
         DONE: begin
            // Retiring and accepting on the same edge keeps throughput at Nr+1 cycles per block.
            in_ready = out_ready;
            if (out_ready) stateNext = in_valid ? ROUND : IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clks) begin
      // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         out_data <= '0;
         out_tag  <= '0;
      end else begin
         state <= stateNext;
         if (accept)                 cnt <= 4'(Nr - 1);
         else if (busy && !lastRound) cnt <= cnt - 4'd1;
         if (busy && lastRound) begin
            out_data <= roundOut;
            out_tag  <= tagReg;
         end
      end
   end

   // NOTE: the wide working registers are not reset; they are always reloaded on accept before use.
   always_ff @(posedge clks) begin
      if (accept) begin
         stateReg <= in_data ^ in_keys[BLOCK_W*Nr +: BLOCK_W];
         keysReg  <= in_keys;
         tagReg   <= in_tag;
      end else if (busy) begin
         stateReg <= roundOut;
      end
   end

   aes_inv_round_core uRound (
      .stateIn  (stateReg),
      .roundKey (roundKey),
      .isFinal  (lastRound),
      .stateOut (roundOut)
   );

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter using FIPS-197 vectors at Nk = 4, 6 and 8.
// Round-key schedules are expanded here from an S-box derived from GF(2^8) inversion.
module tb_aes_inv_cipher_iter;

   localparam int TAG_W = 8;
   localparam int KW    = 128 * 15;

   localparam logic [0:255] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [0:255] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [0:127] CT_C4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [0:127] CT_C6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [0:127] CT_C8 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [0:127] PT_C  = 128'h00112233445566778899aabbccddeeff;

   logic clks = 1'b0;
   logic reset;
   always #5 clks = ~clks;

   logic [2:0]                inValid, inReady, outValid, outReady, busy;
   logic [0:2][0:127]         inData, outData;
   logic [0:2][0:KW-1]        inKeys;
   logic [0:2][TAG_W-1:0]     inTag, outTag;
   logic [0:2][3:0]           roundIdx;

   int nChecks = 0;
   int nErrors = 0;
   logic [7:0]   sboxTab [256];
   logic [0:KW-1] ksB, ksC4, ksC6, ksC8;

   aes_inv_cipher_iter #(.Nk(4), .TAG_W(TAG_W)) dut4 (
      .clks(clks), .reset(reset), .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]),
      .in_keys(inKeys[0][0:128*11-1]), .in_tag(inTag[0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
      .out_data(outData[0]), .out_tag(outTag[0]), .busy(busy[0]), .round_idx(roundIdx[0]));

   aes_inv_cipher_iter #(.Nk(6), .TAG_W(TAG_W)) dut6 (
      .clks(clks), .reset(reset), .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]),
      .in_keys(inKeys[1][0:128*13-1]), .in_tag(inTag[1]), .out_valid(outValid[1]), .out_ready(outReady[1]),
      .out_data(outData[1]), .out_tag(outTag[1]), .busy(busy[1]), .round_idx(roundIdx[1]));

   aes_inv_cipher_iter #(.Nk(8), .TAG_W(TAG_W)) dut8 (
      .clks(clks), .reset(reset), .in_valid(inValid[2]), .in_ready(inReady[2]), .in_data(inData[2]),
      .in_keys(inKeys[2][0:128*15-1]), .in_tag(inTag[2]), .out_valid(outValid[2]), .out_ready(outReady[2]),
      .out_data(outData[2]), .out_tag(outTag[2]), .busy(busy[2]), .round_idx(roundIdx[2]));

   function automatic logic [7:0] tbMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction

   task automatic buildSbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (tbMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sboxTab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subWord(input logic [31:0] t);
      return {sboxTab[t[31:24]], sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]]};
   endfunction

   function automatic logic [0:KW-1] keyExpand(input logic [0:255] key, input int nk);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [0:KW-1] ks;
      rc = 8'h01;
      ks = '0;
      for (int i = 0; i < 4 * (nk + 7); i++) begin
         if (i < nk) begin
            w[i] = key[32*i +: 32];
         end else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
               t = subWord(t);
            end
            w[i] = w[i-nk] ^ t;
         end
         ks[32*i +: 32] = w[i];
      end
      return ks;
   endfunction

   // Offers one block, optionally scrambles the inputs right after acceptance, waits for the
   // result with out_ready low, then retires it. lat counts edges from accept to out_valid.
   task automatic driveBlock(input int k, input logic [0:KW-1] keys, input logic [0:127] ct,
                             input logic [TAG_W-1:0] tag, input bit scramble,
                             output int lat, output logic [0:127] pt, output logic [TAG_W-1:0] tg);
      @(negedge clks);
      inData[k] = ct; inKeys[k] = keys; inTag[k] = tag; outReady[k] = 1'b0; inValid[k] = 1'b1;
      @(negedge clks);
      inValid[k] = 1'b0;
      if (scramble) begin
         for (int i = 0; i < KW / 32; i++) inKeys[k][32*i +: 32] = $urandom;
         inData[k] = {$urandom, $urandom, $urandom, $urandom};
      end
      lat = 0;
      while (!outValid[k] && lat < 40) begin
         @(negedge clks);
         lat++;
      end
      pt = outData[k];
      tg = outTag[k];
      outReady[k] = 1'b1;
      @(negedge clks);
      outReady[k] = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clks);
      for (int k = 0; k < 3; k++) begin
         nChecks++; if (outValid[k] !== 1'b0) begin nErrors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, outValid[k]); end
         nChecks++; if (busy[k] !== 1'b0) begin nErrors++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy[k]); end
         nChecks++; if (inReady[k] !== 1'b1) begin nErrors++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, inReady[k]); end
         nChecks++; if (roundIdx[k] !== 4'd0) begin nErrors++; $display("FAIL reset_round_idx[%0d]: got %0d expected 0", k, roundIdx[k]); end
         nChecks++; if (outData[k] !== 128'h0) begin nErrors++; $display("FAIL reset_out_data[%0d]: got %h expected 0", k, outData[k]); end
         nChecks++; if (outTag[k] !== 8'h00) begin nErrors++; $display("FAIL reset_out_tag[%0d]: got %h expected 00", k, outTag[k]); end
      end
      reset = 1'b0;
   endtask

   task automatic test_fips_vector();
      int lat; logic [0:127] pt; logic [TAG_W-1:0] tg;
      driveBlock(0, ksB, CT_B, 8'ha5, 1'b0, lat, pt, tg);
      nChecks++; if (lat !== 10) begin nErrors++; $display("FAIL fips_latency: got %0d expected 10", lat); end
      nChecks++; if (pt !== PT_B) begin nErrors++; $display("FAIL fips_data: got %h expected %h", pt, PT_B); end
      nChecks++; if (tg !== 8'ha5) begin nErrors++; $display("FAIL fips_tag: got %h expected a5", tg); end
      nChecks++; if (outValid[0] !== 1'b0) begin nErrors++; $display("FAIL fips_retire: got %b expected 0", outValid[0]); end
   endtask

   task automatic test_appendix_c();
      int lat; logic [0:127] pt; logic [TAG_W-1:0] tg;
      logic [0:KW-1] ks; logic [0:127] ct;
      for (int k = 0; k < 3; k++) begin
         ks = (k == 0) ? ksC4 : (k == 1) ? ksC6 : ksC8;
         ct = (k == 0) ? CT_C4 : (k == 1) ? CT_C6 : CT_C8;
         driveBlock(k, ks, ct, 8'(8'h30 + k), 1'b0, lat, pt, tg);
         nChecks++; if (lat !== 10 + 2 * k) begin nErrors++; $display("FAIL appc_latency[Nk=%0d]: got %0d expected %0d", 4 + 2 * k, lat, 10 + 2 * k); end
         nChecks++; if (pt !== PT_C) begin nErrors++; $display("FAIL appc_data[Nk=%0d]: got %h expected %h", 4 + 2 * k, pt, PT_C); end
         nChecks++; if (tg !== 8'(8'h30 + k)) begin nErrors++; $display("FAIL appc_tag[Nk=%0d]: got %h expected %h", 4 + 2 * k, tg, 8'(8'h30 + k)); end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      @(negedge clks);
      inData[0] = CT_B; inKeys[0] = ksB; inTag[0] = 8'h5a; outReady[0] = 1'b0; inValid[0] = 1'b1;
      @(negedge clks);
      inValid[0] = 1'b0;
      lat = 0;
      while (!outValid[0] && lat < 40) begin @(negedge clks); lat++; end
      nChecks++; if (lat !== 10) begin nErrors++; $display("FAIL bp_latency: got %0d expected 10", lat); end
      inData[0] = CT_C4; inKeys[0] = ksC4; inTag[0] = 8'h77; inValid[0] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         nChecks++; if (outValid[0] !== 1'b1) begin nErrors++; $display("FAIL bp_hold_valid@%0d: got %b expected 1", i, outValid[0]); end
         nChecks++; if (outData[0] !== PT_B) begin nErrors++; $display("FAIL bp_hold_data@%0d: got %h expected %h", i, outData[0], PT_B); end
         nChecks++; if (outTag[0] !== 8'h5a) begin nErrors++; $display("FAIL bp_hold_tag@%0d: got %h expected 5a", i, outTag[0]); end
         nChecks++; if (inReady[0] !== 1'b0) begin nErrors++; $display("FAIL bp_in_ready@%0d: got %b expected 0", i, inReady[0]); end
         nChecks++; if (busy[0] !== 1'b0) begin nErrors++; $display("FAIL bp_no_accept@%0d: got busy %b expected 0", i, busy[0]); end
         @(negedge clks);
      end
      outReady[0] = 1'b1;
      #1;
      nChecks++; if (inReady[0] !== 1'b1) begin nErrors++; $display("FAIL bp_ready_follows: got %b expected 1", inReady[0]); end
      @(negedge clks);
      outReady[0] = 1'b0; inValid[0] = 1'b0;
      nChecks++; if (busy[0] !== 1'b1) begin nErrors++; $display("FAIL bp_second_accept: got busy %b expected 1", busy[0]); end
      nChecks++; if (roundIdx[0] !== 4'd9) begin nErrors++; $display("FAIL bp_round_idx: got %0d expected 9", roundIdx[0]); end
      nChecks++; if (outValid[0] !== 1'b0) begin nErrors++; $display("FAIL bp_retired: got %b expected 0", outValid[0]); end
      lat = 0;
      while (!outValid[0] && lat < 40) begin @(negedge clks); lat++; end
      nChecks++; if (lat !== 10) begin nErrors++; $display("FAIL bp_second_latency: got %0d expected 10", lat); end
      nChecks++; if (outData[0] !== PT_C) begin nErrors++; $display("FAIL bp_second_data: got %h expected %h", outData[0], PT_C); end
      nChecks++; if (outTag[0] !== 8'h77) begin nErrors++; $display("FAIL bp_second_tag: got %h expected 77", outTag[0]); end
      outReady[0] = 1'b1;
      @(negedge clks);
      outReady[0] = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [0:127]      gotData [2];
      logic [TAG_W-1:0]  gotTag [2];
      int acc [2];
      int nOut, blk;
      gotData[0] = '0; gotData[1] = '0; gotTag[0] = '0; gotTag[1] = '0;
      acc[0] = 0; acc[1] = -100; nOut = 0; blk = 0;
      outReady[0] = 1'b1;
      for (int i = 0; i < 80 && nOut < 2; i++) begin
         @(negedge clks);
         if (outValid[0]) begin gotData[nOut] = outData[0]; gotTag[nOut] = outTag[0]; nOut++; end
         if (blk == 0) begin inData[0] = CT_B; inKeys[0] = ksB; inTag[0] = 8'h11; inValid[0] = 1'b1; end
         else if (blk == 1) begin inData[0] = CT_C4; inKeys[0] = ksC4; inTag[0] = 8'h22; inValid[0] = 1'b1; end
         else inValid[0] = 1'b0;
         #1;
         if (inValid[0] && inReady[0]) begin acc[blk] = i; blk++; end
      end
      inValid[0] = 1'b0;
      @(negedge clks);
      outReady[0] = 1'b0;
      nChecks++; if (acc[1] - acc[0] !== 11) begin nErrors++; $display("FAIL b2b_spacing: got %0d expected 11", acc[1] - acc[0]); end
      nChecks++; if (gotData[0] !== PT_B) begin nErrors++; $display("FAIL b2b_data0: got %h expected %h", gotData[0], PT_B); end
      nChecks++; if (gotTag[0] !== 8'h11) begin nErrors++; $display("FAIL b2b_tag0: got %h expected 11", gotTag[0]); end
      nChecks++; if (gotData[1] !== PT_C) begin nErrors++; $display("FAIL b2b_data1: got %h expected %h", gotData[1], PT_C); end
      nChecks++; if (gotTag[1] !== 8'h22) begin nErrors++; $display("FAIL b2b_tag1: got %h expected 22", gotTag[1]); end
      nChecks++; if (outValid[0] !== 1'b0) begin nErrors++; $display("FAIL b2b_drained: got %b expected 0", outValid[0]); end
   endtask

   task automatic test_reset_mid_op();
      int n, lat; bit sawOut; logic [0:127] pt; logic [TAG_W-1:0] tg;
      @(negedge clks);
      inData[0] = CT_B; inKeys[0] = ksB; inTag[0] = 8'h3c; outReady[0] = 1'b0; inValid[0] = 1'b1;
      @(negedge clks);
      inValid[0] = 1'b0;
      n = 0;
      while (roundIdx[0] !== 4'd5 && n < 20) begin @(negedge clks); n++; end
      nChecks++; if (roundIdx[0] !== 4'd5) begin nErrors++; $display("FAIL rst_reach_round5: got %0d expected 5", roundIdx[0]); end
      reset = 1'b1;
      @(negedge clks);
      nChecks++; if (outValid[0] !== 1'b0) begin nErrors++; $display("FAIL rst_out_valid: got %b expected 0", outValid[0]); end
      nChecks++; if (outData[0] !== 128'h0) begin nErrors++; $display("FAIL rst_out_data: got %h expected 0", outData[0]); end
      nChecks++; if (outTag[0] !== 8'h00) begin nErrors++; $display("FAIL rst_out_tag: got %h expected 00", outTag[0]); end
      nChecks++; if (busy[0] !== 1'b0) begin nErrors++; $display("FAIL rst_busy: got %b expected 0", busy[0]); end
      nChecks++; if (roundIdx[0] !== 4'd0) begin nErrors++; $display("FAIL rst_round_idx: got %0d expected 0", roundIdx[0]); end
      nChecks++; if (inReady[0] !== 1'b1) begin nErrors++; $display("FAIL rst_in_ready: got %b expected 1", inReady[0]); end
      reset = 1'b0;
      sawOut = 1'b0;
      repeat (15) begin @(negedge clks); if (outValid[0]) sawOut = 1'b1; end
      nChecks++; if (sawOut !== 1'b0) begin nErrors++; $display("FAIL rst_discard: got out_valid after reset, expected none"); end
      driveBlock(0, ksB, CT_B, 8'h3c, 1'b0, lat, pt, tg);
      nChecks++; if (lat !== 10) begin nErrors++; $display("FAIL rst_after_latency: got %0d expected 10", lat); end
      nChecks++; if (pt !== PT_B) begin nErrors++; $display("FAIL rst_after_data: got %h expected %h", pt, PT_B); end
      nChecks++; if (tg !== 8'h3c) begin nErrors++; $display("FAIL rst_after_tag: got %h expected 3c", tg); end
   endtask

   task automatic test_key_latch();
      int lat; logic [0:127] pt; logic [TAG_W-1:0] tg;
      driveBlock(0, ksB, CT_B, 8'h66, 1'b1, lat, pt, tg);
      nChecks++; if (lat !== 10) begin nErrors++; $display("FAIL latch_latency: got %0d expected 10", lat); end
      nChecks++; if (pt !== PT_B) begin nErrors++; $display("FAIL latch_data: got %h expected %h", pt, PT_B); end
      nChecks++; if (tg !== 8'h66) begin nErrors++; $display("FAIL latch_tag: got %h expected 66", tg); end
   endtask

   initial begin
      reset = 1'b1;
      inValid = '0; outReady = '0; inData = '0; inKeys = '0; inTag = '0;
      buildSbox();
      ksB  = keyExpand(KEY_B, 4);
      ksC4 = keyExpand(KEY_C, 4);
      ksC6 = keyExpand(KEY_C, 6);
      ksC8 = keyExpand(KEY_C, 8);
      test_reset();
      test_fips_vector();
      test_appendix_c();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_op();
      test_key_latch();
      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
Iterative AES inverse cipher that decrypts one 128-bit block using one round per clock. It supports AES-128, AES-192 and AES-256 through the Nk parameter. Input and output use valid/ready handshakes, and a user tag travels with each block. It sits between the key-expansion block, which supplies the full expanded schedule, and the decrypted-data consumer.

Parameters:
Nk, 4, key length in 32-bit words; legal values are 4, 6 and 8; any other value is an elaboration error.
Nr, Nk+6, number of rounds; derived, never overridden.
TAG_W, 8, width of the user tag passed through with each block.

Ports:
clks  in  1  clock
reset  in  1  reset, synchronous, active-high
in_valid  in  1  a block is offered on in_data/in_keys/in_tag
in_ready  out  1  block accepted on an edge where in_valid && in_ready
in_data  in  [0:127]  ciphertext, byte 0 at bits [0:7]
in_keys  in  [0:128*(Nr+1)-1]  expanded schedule; round key i at bits [128*i : 128*i+127]
in_tag  in  TAG_W  user tag
out_valid  out  1  plaintext valid
out_ready  in  1  consumer accepts on an edge where out_valid && out_ready
out_data  out  [0:127]  plaintext
out_tag  out  TAG_W  tag of the block on out_data
busy  out  1  high while in state ROUND
round_idx  out  4  round key index used in the current ROUND cycle; 0 when not in ROUND

Behaviour:
- States:
  - IDLE: in_ready=1, out_valid=0.
  - ROUND: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=out_ready.
- Reset:
  - state IDLE; out_valid=0; out_data=0; out_tag=0; round counter=0; busy=0.
  - Reset overrides any in-flight block; that block is discarded with no output.
- Accept edge (in_valid && in_ready):
  - state_reg <= in_data ^ rk[Nr].
  - keys_reg <= in_keys; tag_reg <= in_tag.
  - cnt <= Nr-1; state -> ROUND.
  - Keys are latched, so in_keys may change after acceptance.
- ROUND, cnt>=1 (standard round): state_reg <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state_reg)), rk[cnt])); cnt <= cnt-1.
- ROUND, cnt==0 (final round): out_data <= AddRoundKey(InvSubBytes(InvShiftRows(state_reg)), rk[0]); out_tag <= tag_reg; state -> DONE.
- round_idx equals cnt while in ROUND.
- Latency: out_valid rises exactly Nr cycles after the accept edge (10, 12 or 14 cycles).
- DONE:
  - out_data/out_tag held stable until out_ready.
  - out_ready && !in_valid: -> IDLE.
  - out_ready && in_valid: output retired and new block accepted on the same edge; go straight to ROUND.
  - Sustained throughput is one block per Nr+1 cycles.
- No combinational path from out_ready to any output other than in_ready.
- round_idx is 4 bits, enough for Nr=14; cnt never wraps below 0.
- in_valid while busy is ignored (in_ready=0); the upstream block must hold its request until accepted.

Decomposition:
- Shared package aes_pkg holds:
  - the S-box and inverse S-box constants;
  - the function nr_of(Nk);
  - state encodings IDLE/ROUND/DONE;
  - the constant BLOCK_W=128.
- Sub-module aes_inv_round_core: purely combinational round with inputs state, round key and is_final (bypasses InvMixColumns when set).
- The top level holds only the FSM, counter, latches and handshake.

Test Plan:
1. Nk=4, FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, in_data 3925841d02dc09fbdc118597196a0b32 -> out_data 3243f6a8885a308d313198a2e0370734, out_valid exactly 10 cycles after accept.
2. Nk=4/6/8, App. C key 000102…(Nk*4 bytes): ct 69c4e0d86a7b0430d8cdb78070b4c55a / dda97ca4864cdfe06eaf70a0ec0d7191 / 8ea2b7ca516745bfeafc49904b496089 -> pt 00112233445566778899aabbccddeeff; latency 10/12/14.
3. Backpressure: hold out_ready=0 for 20 cycles after done -> out_valid, out_data and out_tag stable; in_ready=0; a second in_valid is not accepted until the out_ready edge.
4. Back-to-back: in_valid and out_ready held high with tags 0x11 and 0x22 -> two correct outputs in order, accepts spaced Nr+1 cycles, tags match their blocks.
5. Reset mid-operation: reset asserted at round_idx=5 -> next cycle IDLE, out_valid=0, out_data=0; the following block decrypts correctly with no residue.
6. Key-latch check: change in_keys to random data one cycle after accept -> output still matches test 1.
